mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the byte address width.
REQ-002 The block SHALL have port clk, input, 1 bit: clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port if_req, input, 1 bit: instruction fetch request, held until if_done.
REQ-005 The block SHALL have port if_addr, input, ADDR_W bits: byte address of the instruction's first byte.
REQ-006 The block SHALL have port if_instr, output, 32 bits: assembled instruction word.
REQ-007 The block SHALL have port if_done, output, 1 bit: one-cycle pulse, if_instr valid.
REQ-008 The block SHALL have port d_req, input, 1 bit: data access request, held until d_done.
REQ-009 The block SHALL have port d_we, input, 1 bit: 1 = store byte, 0 = load byte.
REQ-010 The block SHALL have port d_addr, input, ADDR_W bits: data byte address.
REQ-011 The block SHALL have port d_wdata, input, 8 bits: store data.
REQ-012 The block SHALL have port d_rdata, output, 8 bits: load data.
REQ-013 The block SHALL have port d_done, output, 1 bit: one-cycle pulse, access complete, d_rdata valid for loads.
REQ-014 The block SHALL have port mem_req, output, 1 bit: memory byte request, held until mem_ack.
REQ-015 The block SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-016 The block SHALL have port mem_addr, output, ADDR_W bits: memory byte address.
REQ-017 The block SHALL have port mem_wdata, output, 8 bits: memory write data.
REQ-018 The block SHALL have port mem_rdata, input, 8 bits: memory read data, valid when mem_ack=1.
REQ-019 The block SHALL have port mem_ack, input, 1 bit: memory completes the current byte in this cycle; may be 1 in the same cycle mem_req rises.
REQ-020 The block SHALL have port busy, output, 1 bit: 1 when state is not IDLE.

Function
REQ-021 The block SHALL implement the states IDLE, FETCH, DATA and RESP, with all outputs driven from registers.
REQ-022 In IDLE with d_req=1, the block SHALL latch d_addr, d_we and d_wdata and go to DATA; d_req has priority over if_req.
REQ-023 In IDLE with d_req=0 and if_req=1, the block SHALL latch if_addr, clear the 2-bit byte counter and go to FETCH.
REQ-024 In FETCH and DATA, mem_req SHALL be 1, mem_addr SHALL be stable until mem_ack, and mem_we SHALL be 1 only for a DATA store.
REQ-025 In FETCH, mem_addr SHALL equal latched address + byte counter, modulo 2^ADDR_W (0xFF+1 wraps to 0x00 for ADDR_W=8).
REQ-026 On mem_ack in FETCH, mem_rdata for byte k SHALL be stored into if_instr[8k+7:8k], and the counter SHALL increment.
REQ-027 For k<3, the next byte SHALL be requested in the following cycle with mem_req held high; k=3 SHALL go to RESP.
REQ-028 On mem_ack in DATA, mem_rdata SHALL be captured into d_rdata for loads, d_rdata SHALL hold its previous value for stores, and the block SHALL go to RESP.
REQ-029 RESP SHALL last exactly one cycle, SHALL assert if_done or d_done (owner only), SHALL hold mem_req=0, and SHALL then return to IDLE.
REQ-030 A requester SHALL drop its req at the edge ending RESP; requests arriving during FETCH, DATA or RESP SHALL wait, and a grant SHALL never be preempted.
REQ-031 mem_ack while mem_req=0 SHALL be ignored.
REQ-032 if_instr and d_rdata SHALL hold their values until overwritten by a later access.
REQ-033 With zero-wait memory (mem_ack=mem_req), a fetch SHALL give if_done 5 cycles after the IDLE cycle that samples if_req, and a data access SHALL give d_done 2 cycles after.

Reset
REQ-034 On reset, the block SHALL enter state IDLE, drive mem_req, mem_we, if_done, d_done and busy to 0, and clear mem_addr, mem_wdata, if_instr, d_rdata and the byte counter to 0.
REQ-035 Reset mid-operation SHALL abort the access without a done pulse; mem_req SHALL be 0 in the cycle after reset is sampled.

Verification
REQ-036 Zero-wait fetch, if_addr=0x10, memory bytes 0x11,0x22,0x33,0x44 -> mem_addr 0x10..0x13, if_instr=0x44332211, if_done 5 cycles after grant.
REQ-037 if_req and d_req asserted together in IDLE, d_we=0, d_addr=0x80 -> DATA served first, d_done before any FETCH mem_req; fetch completes afterwards.
REQ-038 Fetch with if_addr=0xFE (ADDR_W=8) and 2 wait cycles per byte -> mem_addr 0xFE,0xFF,0x00,0x01; mem_addr stable while waiting.
REQ-039 Store d_addr=0x20, d_wdata=0xA5 -> mem_we=1, mem_wdata=0xA5 until mem_ack, d_done one cycle, d_rdata unchanged.
REQ-040 Reset asserted after the second fetch byte -> no if_done, mem_req=0 next cycle, busy=0, and a new d_req is then served normally.
REQ-041 Spurious mem_ack in IDLE -> no state change, no done pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares a single byte-wide memory port between an instruction fetch port
// (four-byte little-endian word assembled from consecutive addresses) and a
// data port (single byte load/store). The data port wins ties; a granted
// access always runs to completion. Every output comes straight from a flop.

module mem_port_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_instr,
  output logic              if_done,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [7:0]        d_wdata,
  output logic [7:0]        d_rdata,
  output logic              d_done,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  // status
  output logic              busy
);

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // State and output registers
  logic [1:0]        state_q,     state_d;
  logic [1:0]        cnt_q,       cnt_d;
  logic [ADDR_W-1:0] base_q,      base_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_instr_q,  if_instr_d;
  logic [7:0]        d_rdata_q,   d_rdata_d;
  logic              if_done_q,   if_done_d;
  logic              d_done_q,    d_done_d;
  logic              busy_q,      busy_d;

  // Helper signals
  logic              ack_s;
  logic [1:0]        cnt_inc_s;
  logic [ADDR_W-1:0] fetch_next_addr_s;

  // Writes one byte lane of the instruction word; lane k holds bits 8k+7:8k.
  function automatic logic [31:0] put_byte(
    input logic [31:0] word,
    input logic [1:0]  lane,
    input logic [7:0]  data
  );
    logic [31:0] res;
    res = word;
    case (lane)
      2'd0:    res[7:0]   = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[23:16] = data;
      2'd3:    res[31:24] = data;
      default: res        = word;
    endcase
    return res;
  endfunction

  // An acknowledge only counts while a request is actually outstanding.
  assign ack_s             = mem_req_q & mem_ack;
  assign cnt_inc_s         = cnt_q + 2'd1;
  // Address of the following fetch byte; the add wraps modulo 2^ADDR_W.
  assign fetch_next_addr_s = base_q + ADDR_W'(cnt_inc_s);

  // Next-state and next-output computation for the arbitration controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_instr_d  = if_instr_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (d_req) begin
          // Data requests win over fetches sampled in the same cycle.
          state_d     = ST_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          busy_d      = 1'b1;
        end else if (if_req) begin
          state_d     = ST_FETCH;
          base_d      = if_addr;
          cnt_d       = 2'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          busy_d      = 1'b1;
        end else begin
          // Stray acknowledges are ignored here: nothing changes.
          state_d     = ST_IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          busy_d      = 1'b0;
        end
      end

      ST_FETCH: begin
        if (ack_s) begin
          if_instr_d = put_byte(if_instr_q, cnt_q, mem_rdata);
          cnt_d      = cnt_inc_s;
          if (cnt_q == 2'd3) begin
            state_d   = ST_RESP;
            mem_req_d = 1'b0;
            if_done_d = 1'b1;
          end else begin
            // Keep mem_req high and move straight on to the next byte.
            mem_addr_d = fetch_next_addr_s;
          end
        end else begin
          // Waiting on memory: request and address stay frozen.
          state_d = ST_FETCH;
        end
      end

      ST_DATA: begin
        if (ack_s) begin
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            // Stores leave the last load value visible.
            d_rdata_d = d_rdata_q;
          end
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_done_d  = 1'b1;
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_RESP: begin
        // Single response cycle; the done pulse was launched on entry.
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        busy_d    = 1'b0;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // Register update with synchronous reset that also aborts any access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      base_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      if_instr_q  <= 32'h0000_0000;
      d_rdata_q   <= 8'h00;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_instr_q  <= if_instr_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
    end
  end

  assign if_instr  = if_instr_q;
  assign if_done   = if_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
